// File: rtl/fifo_burst_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_drain_if
// Description : Bus bundle for the burst drain engine: FIFO read side, flush
//               and address-load controls, burst request and write-beat ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_burst_drain_if #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 2,
  parameter int ADDR_W = 12
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [WIDTH-1:0]  fifo_rd_data;
  logic              flush;
  logic              addr_load;
  logic [ADDR_W-1:0] base_addr;
  logic              bst_req;
  logic [ADDR_W-1:0] bst_addr;
  logic [CNT_W:0]    bst_len;
  logic              bst_ack;
  logic              dat_valid;
  logic [WIDTH-1:0]  dat_out;
  logic              dat_last;
  logic              dat_ready;
  logic              busy;

  // Engine side
  modport master (
    input  fifo_empty, fifo_rd_data, flush, addr_load, base_addr, bst_ack, dat_ready,
    output fifo_rd_en, bst_req, bst_addr, bst_len, dat_valid, dat_out, dat_last, busy
  );

  // Environment side (FIFO, controller, SDRAM write path)
  modport slave (
    output fifo_empty, fifo_rd_data, flush, addr_load, base_addr, bst_ack, dat_ready,
    input  fifo_rd_en, bst_req, bst_addr, bst_len, dat_valid, dat_out, dat_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_burst_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_drain
// Description : Drains a write-data FIFO into a staging buffer and issues
//               bursts of up to BURST_LEN words (FILL -> REQ -> SEND), with
//               flush for partial bursts and a wrapping address pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_drain #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 2,
  parameter int ADDR_W    = 12
) (
  input wire logic            clk,
  input wire logic            rst_n,
  fifo_burst_drain_if.master  bus
);

  localparam logic [1:0]     c_FILL = 2'd0;
  localparam logic [1:0]     c_REQ  = 2'd1;
  localparam logic [1:0]     c_SEND = 2'd2;
  localparam logic [CNT_W:0] c_FULL = (CNT_W+1)'(BURST_LEN);
  localparam logic [CNT_W:0] c_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] c_ZERO = '0;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [CNT_W:0]    r_fill_cnt;
  logic [CNT_W:0]    r_iss_cnt;
  logic [CNT_W:0]    r_beat;
  logic              r_flush_pend;
  logic              r_cap_pend;   // a pop was issued last cycle; its data arrives now
  logic              r_run;        // holds off popping until the first edge after reset
  logic [ADDR_W-1:0] r_addr_ptr;
  logic [WIDTH-1:0]  r_buf [0:BURST_LEN-1];

  logic w_pop;
  logic w_go_req;
  logic w_last;
  logic w_beat_acc;
  logic w_done;

  assign w_pop      = (r_state == c_FILL) && r_run && !bus.fifo_empty &&
                      !r_flush_pend && (r_iss_cnt < c_FULL);
  assign w_go_req   = (r_fill_cnt == c_FULL) ||
                      (r_flush_pend && !r_cap_pend && (r_fill_cnt != c_ZERO));
  assign w_last     = (r_beat == (r_fill_cnt - c_ONE));
  assign w_beat_acc = (r_state == c_SEND) && bus.dat_ready;
  assign w_done     = w_beat_acc && w_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_FILL;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_FILL:  if (w_go_req)    w_next = c_REQ;
      c_REQ:   if (bus.bst_ack) w_next = c_SEND;
      c_SEND:  if (w_done)      w_next = c_FILL;
      default:                  w_next = c_FILL;
    endcase
  end

  // Outputs decoded from state and registers only
  always_comb begin
    bus.fifo_rd_en = w_pop;
    bus.bst_req    = (r_state == c_REQ);
    bus.bst_addr   = r_addr_ptr;
    bus.bst_len    = r_fill_cnt;
    bus.dat_valid  = (r_state == c_SEND);
    bus.dat_out    = '0;
    bus.dat_last   = 1'b0;
    bus.busy       = (r_state == c_REQ) || (r_state == c_SEND);
    if (r_state == c_SEND) begin
      bus.dat_out  = r_buf[r_beat[CNT_W-1:0]];
      bus.dat_last = w_last;
    end
  end

  // Counters, flush tracking and address pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run        <= 1'b0;
      r_cap_pend   <= 1'b0;
      r_fill_cnt   <= '0;
      r_iss_cnt    <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      r_addr_ptr   <= '0;
    end else begin
      r_run      <= 1'b1;
      r_cap_pend <= w_pop;
      if (w_pop)      r_iss_cnt  <= r_iss_cnt + c_ONE;
      if (r_cap_pend) r_fill_cnt <= r_fill_cnt + c_ONE;
      if (r_state == c_FILL) begin
        // A flush with nothing staged or in flight is simply dropped
        if (bus.flush)
          r_flush_pend <= 1'b1;
        else if (r_flush_pend && !r_cap_pend && (r_fill_cnt == c_ZERO))
          r_flush_pend <= 1'b0;
        if (bus.addr_load) r_addr_ptr <= bus.base_addr;
      end
      if (w_beat_acc) begin
        if (w_last) begin
          r_addr_ptr   <= r_addr_ptr + ADDR_W'(r_fill_cnt);
          r_fill_cnt   <= '0;
          r_iss_cnt    <= '0;
          r_beat       <= '0;
          r_flush_pend <= 1'b0;
        end else begin
          r_beat <= r_beat + c_ONE;
        end
      end
    end
  end

  // Staging buffer: capture the word returned one cycle after each pop
  always_ff @(posedge clk) begin
    if (r_cap_pend && (r_fill_cnt != c_FULL))
      r_buf[r_fill_cnt[CNT_W-1:0]] <= bus.fifo_rd_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_drain
// Description : Directed self-checking bench for fifo_burst_drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_drain;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Simple FIFO model: tb pushes, DUT pops, data one cycle after pop
  logic [7:0] fmem [0:63];
  int fwp = 0;
  int frp = 0;

  fifo_burst_drain_if #(.WIDTH(8), .CNT_W(2), .ADDR_W(12)) bus ();

  fifo_burst_drain #(.WIDTH(8), .BURST_LEN(4), .CNT_W(2), .ADDR_W(12)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_empty = (fwp == frp);

  // FIFO read port
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= fmem[frp % 64];
      frp <= frp + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fmem[fwp % 64] = v;
    fwp++;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max);
    int c;
    c = 0;
    while (!bus.bst_req && c < max) begin
      @(negedge clk);
      c++;
    end
    check_val({tag, "_req_seen"}, 32'(bus.bst_req), 32'd1);
  endtask

  // Handshake one burst: check request, hold off ack 2 cycles, then collect beats
  task automatic run_burst(input string tag, input logic [11:0] exp_addr, input int len,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3, input bit bp);
    logic [7:0] exp_w [4];
    int k;
    int c;
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
    k = 0;
    c = 0;
    wait_req(tag, 40);
    check_val({tag, "_addr"}, 32'(bus.bst_addr), 32'(exp_addr));
    check_val({tag, "_len"}, 32'(bus.bst_len), 32'(len));
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check_val({tag, "_rden_req"}, 32'(bus.fifo_rd_en), 32'd0);
    bus.bst_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val({tag, "_req_hold"}, 32'(bus.bst_req), 32'd1);
      check_val({tag, "_addr_hold"}, 32'(bus.bst_addr), 32'(exp_addr));
      check_val({tag, "_len_hold"}, 32'(bus.bst_len), 32'(len));
    end
    bus.bst_ack = 1'b1;
    @(negedge clk);
    bus.bst_ack = 1'b0;
    while (k < len && c < 40) begin
      bus.dat_ready = bp ? (c % 3 == 0) : 1'b1;
      check_val({tag, "_valid"}, 32'(bus.dat_valid), 32'd1);
      check_val({tag, "_data"}, 32'(bus.dat_out), 32'(exp_w[k]));
      check_val({tag, "_last"}, 32'(bus.dat_last), 32'(k == len - 1));
      if (bus.dat_ready) k++;
      c++;
      @(negedge clk);
    end
    bus.dat_ready = 1'b0;
    check_val({tag, "_beats"}, 32'(k), 32'(len));
    check_val({tag, "_valid_end"}, 32'(bus.dat_valid), 32'd0);
    check_val({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.flush     = 1'b0;
    bus.addr_load = 1'b1;
    bus.base_addr = 12'h100;
    bus.bst_ack   = 1'b0;
    bus.dat_ready = 1'b0;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);

    // Reset state with data waiting in the FIFO
    repeat (3) @(negedge clk);
    check_val("rst_rden",  32'(bus.fifo_rd_en), 32'd0);
    check_val("rst_req",   32'(bus.bst_req),    32'd0);
    check_val("rst_valid", 32'(bus.dat_valid),  32'd0);
    check_val("rst_last",  32'(bus.dat_last),   32'd0);
    check_val("rst_busy",  32'(bus.busy),       32'd0);
    check_val("rst_dout",  32'(bus.dat_out),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.addr_load = 1'b0;

    // Full burst from 0x100
    run_burst("full", 12'h100, 4, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0);

    // Partial burst forced by flush; pointer now 0x104
    push(8'hB0); push(8'hB1);
    repeat (6) @(negedge clk);
    check_val("partial_noreq", 32'(bus.bst_req), 32'd0);
    pulse_flush();
    run_burst("partial", 12'h104, 2, 8'hB0, 8'hB1, 8'h00, 8'h00, 1'b0);

    // Starved FIFO after one pop, then refill with backpressure
    push(8'h30);
    repeat (6) @(negedge clk);
    check_val("starve_req",  32'(bus.bst_req),    32'd0);
    check_val("starve_busy", 32'(bus.busy),       32'd0);
    check_val("starve_rden", 32'(bus.fifo_rd_en), 32'd0);
    push(8'h31); push(8'h32); push(8'h33);
    run_burst("bp", 12'h106, 4, 8'h30, 8'h31, 8'h32, 8'h33, 1'b1);

    // Flush with nothing staged: no burst, and popping resumes afterwards
    pulse_flush();
    for (int i = 0; i < 6; i++) begin
      check_val("empty_flush_noreq", 32'(bus.bst_req), 32'd0);
      @(negedge clk);
    end
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
    run_burst("after_flush", 12'h10A, 4, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 1'b0);

    // Address wrap-around from 0xFFE
    bus.addr_load = 1'b1;
    bus.base_addr = 12'hFFE;
    push(8'hE0); push(8'hE1); push(8'hE2); push(8'hE3);
    @(negedge clk);
    bus.addr_load = 1'b0;
    run_burst("wrap", 12'hFFE, 4, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b1);
    push(8'hF0); push(8'hF1);
    repeat (6) @(negedge clk);
    pulse_flush();
    run_burst("wrapped", 12'h002, 2, 8'hF0, 8'hF1, 8'h00, 8'h00, 1'b0);

    // Reset in the middle of SEND after the first beat
    push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
    wait_req("midrst", 40);
    bus.bst_ack = 1'b1;
    @(negedge clk);
    bus.bst_ack   = 1'b0;
    bus.dat_ready = 1'b1;
    @(negedge clk);
    bus.dat_ready = 1'b0;
    check_val("midrst_beat1", 32'(bus.dat_out), 32'h0C1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", 32'(bus.dat_valid),  32'd0);
    check_val("midrst_req",   32'(bus.bst_req),    32'd0);
    check_val("midrst_last",  32'(bus.dat_last),   32'd0);
    check_val("midrst_busy",  32'(bus.busy),       32'd0);
    check_val("midrst_dout",  32'(bus.dat_out),    32'd0);
    check_val("midrst_rden",  32'(bus.fifo_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(8'h90); push(8'h91); push(8'h92); push(8'h93);
    run_burst("postrst", 12'h000, 4, 8'h90, 8'h91, 8'h92, 8'h93, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_burst_drain.md
FIFO_BURST_DRAIN -- requirements
Module: fifo_burst_drain

Interface
REQ-001 Parameter WIDTH, default 8, data word width; matches the write-data FIFO.
REQ-002 Parameter BURST_LEN, default 4, maximum words per burst; power of two, at least 2.
REQ-003 Parameter CNT_W, default 2, log2(BURST_LEN).
REQ-004 Parameter ADDR_W, default 12, burst address width.
REQ-005 clk  input  1  clock, rising-edge active.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_rd_en  output  1  FIFO pop request.
REQ-009 fifo_rd_data  input  WIDTH  FIFO read data; valid in the cycle after fifo_rd_en was high.
REQ-010 flush  input  1  one-cycle pulse; forces a partial burst.
REQ-011 addr_load  input  1  loads base_addr into the address pointer.
REQ-012 base_addr  input  ADDR_W  start address.
REQ-013 bst_req  output  1  burst request to the SDRAM write path.
REQ-014 bst_addr  output  ADDR_W  burst start address.
REQ-015 bst_len  output  CNT_W+1  number of words in the burst (1..BURST_LEN).
REQ-016 bst_ack  input  1  burst request accepted.
REQ-017 dat_valid  output  1  write beat valid.
REQ-018 dat_out  output  WIDTH  write beat data.
REQ-019 dat_last  output  1  final beat of the burst.
REQ-020 dat_ready  input  1  downstream accepts the beat.
REQ-021 busy  output  1  high in REQ or SEND state.

Function
REQ-022 The FSM SHALL have three states: FILL, REQ and SEND.
REQ-023 FILL: fifo_rd_en = !fifo_empty && !flush_pend && (iss_cnt < BURST_LEN); iss_cnt increments on every pop; back-to-back pops are allowed.
REQ-024 A pop in cycle t SHALL cause fifo_rd_data to be written into staging buffer[fill_cnt] at the end of cycle t+1, and fill_cnt SHALL then increment.
REQ-025 FILL to REQ SHALL occur when fill_cnt reaches BURST_LEN, or when flush_pend=1, no capture is pending and fill_cnt>0.
REQ-026 flush SHALL set flush_pend, which blocks new pops. If fill_cnt=0 and no capture is pending, flush_pend SHALL clear without any burst.
REQ-027 REQ: bst_req=1, bst_addr=addr_ptr and bst_len=fill_cnt, all held stable until bst_ack is sampled high; the FSM then moves to SEND.
REQ-028 SEND: dat_valid=1 and dat_out=buffer[beat]; beat advances on dat_valid && dat_ready; dat_last=1 when beat=bst_len-1.
REQ-029 When the last beat is accepted: addr_ptr += bst_len (modulo 2^ADDR_W, wrapping); fill_cnt, iss_cnt, beat and flush_pend clear; the FSM returns to FILL with no idle cycle.
REQ-030 addr_load SHALL take effect only in FILL, next cycle; it is ignored in REQ and SEND.
REQ-031 fifo_rd_en SHALL be 0 outside FILL.
REQ-032 A flush pulse arriving during REQ or SEND SHALL be ignored.
REQ-033 Outputs bst_req and dat_valid SHALL be glitch-free registered or state-decoded signals; bst_ack arriving outside REQ is ignored.

Reset
REQ-034 While rst_n=0: state=FILL; fill_cnt, iss_cnt, beat, flush_pend and addr_ptr are 0; fifo_rd_en, bst_req, dat_valid, dat_last and busy are 0; dat_out is 0.
REQ-035 Reset in the middle of a burst SHALL discard the staged data; the first pop after reset SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-036 Full burst: base_addr=0x100 loaded, 4 words A0..A3 in the FIFO, bst_ack after 2 cycles, dat_ready=1 -> bst_addr=0x100, bst_len=4, beats A0..A3, dat_last on A3, addr_ptr becomes 0x104.
REQ-037 Partial flush: 2 words, then flush -> bst_len=2, two beats, addr_ptr advances by 2; a flush with the FIFO empty and fill_cnt=0 -> no bst_req.
REQ-038 Backpressure: dat_ready toggles 1,0,0,1,... -> every word is delivered exactly once and in order, and dat_out stays stable while stalled.
REQ-039 Wrap-around: addr_ptr=0xFFE with a 4-word burst -> bst_addr=0xFFE, next addr_ptr=0x002.
REQ-040 Starved FIFO: fifo_empty goes high after 1 pop -> stays in FILL with fill_cnt=1 and no bst_req until more data arrives or flush.
REQ-041 Reset during SEND after beat 1 -> all outputs go to 0 immediately; after release, a new burst starts at address 0.
